wrr_arbiter: RTL and testbench

//  Weighted round-robin arbiter with per-port credit and ack-driven grant hold.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/priority_encoder.sv | 42 ++++
 rtl/wrr_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_wrr_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared definitions for the weighted round-robin arbiter:
//     - arb_state_e : two-state arbitration FSM encoding (IDLE, GRANT)
//     - idx_width   : width of an index able to address n requesters
//     - credit_max  : largest credit value a WEIGHT_WIDTH-bit counter can hold
// -----------------------------------------------------------------------------
package arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // Width of a binary index for n requesters (at least one bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Largest credit a counter of the given width can represent.
   function automatic int unsigned credit_max(input int unsigned width);
      return (1 << width) - 1;
   endfunction

endpackage

// File: rtl/priority_encoder.sv
// -----------------------------------------------------------------------------
// priority_encoder
//   Combinational priority encoder returning the index of the winning set bit.
//   Parameters:
//     WIDTH     number of request bits
//     LSB_FIRST 1: lowest set bit wins; 0: highest set bit wins
//   Ports:
//     req_i    in  WIDTH          request vector
//     valid_o  out 1              at least one request bit set
//     index_o  out idx_width      index of the winning bit (0 when none)
// -----------------------------------------------------------------------------
module priority_encoder
   import arb_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int LSB_FIRST = 1
) (
   input  logic [WIDTH-1:0]                  req_i,
   output logic                              valid_o,
   output logic [idx_width(WIDTH)-1:0]       index_o
);

   localparam int IW = idx_width(WIDTH);

   assign valid_o = |req_i;

   // Scan in the direction opposite to priority so the preferred bit is
   // the last one to overwrite the index.
   always_comb begin
      index_o = '0;
      if (LSB_FIRST != 0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) index_o = IW'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (req_i[i]) index_o = IW'(i);
         end
      end
   end

endmodule

// File: rtl/wrr_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_arbiter
//   Weighted round-robin arbiter. Each grant carries a burst credit loaded from
//   the winning port's weight (0 loads 1); every acknowledged transfer spends
//   one credit. The grant is released on the last credit, on withdrawal of the
//   request, or (optionally) on a hold timeout, and the next winner is chosen
//   in the same cycle so back-to-back grants have no idle gap.
//
//   Optional feature macro: ARB_HOLD_TIMEOUT_EN
//     Defined   : a hold counter revokes a grant that has seen no transfer for
//                 HOLD_LIMIT cycles while another port is requesting; the
//                 revoke is flagged by a one-cycle timeout_event pulse.
//     Undefined : grants are held until credit is spent or request drops;
//                 timeout_event is tied low.
//
//   Ports:
//     clk           in  1                   clock, rising edge
//     rst_n         in  1                   asynchronous active-low reset
//     request       in  PORTS               per-port request level
//     acknowledge   in  PORTS               per-port transfer ack (granted bit only)
//     weight        in  PORTS*WEIGHT_WIDTH  port i weight at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//     grant         out PORTS               one-hot registered grant
//     grant_valid   out 1                   a grant is active
//     grant_encoded out $clog2(PORTS)       index of the granted port
//     grant_credit  out WEIGHT_WIDTH        transfers remaining in the current grant
//     timeout_event out 1                   one-cycle pulse on a hold-timeout revoke
// -----------------------------------------------------------------------------
module wrr_arbiter
   import arb_pkg::*;
#(
   parameter int PORTS                 = 4,
   parameter int WEIGHT_WIDTH          = 4,
   parameter int ARB_LSB_HIGH_PRIORITY = 1,
   parameter int HOLD_LIMIT            = 64
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [PORTS-1:0]                 request,
   input  logic [PORTS-1:0]                 acknowledge,
   input  logic [PORTS*WEIGHT_WIDTH-1:0]    weight,
   output logic [PORTS-1:0]                 grant,
   output logic                             grant_valid,
   output logic [$clog2(PORTS)-1:0]         grant_encoded,
   output logic [WEIGHT_WIDTH-1:0]          grant_credit,
   output logic                             timeout_event
);

   localparam int IW = idx_width(PORTS);
   // The pointer starts where the first search lands on the preferred end.
   localparam logic [IW-1:0] PTR_RST = (ARB_LSB_HIGH_PRIORITY != 0) ? IW'(PORTS - 1) : '0;

   if (PORTS < 2 || HOLD_LIMIT < 1) begin : g_param_check
      $error("wrr_arbiter: PORTS must be >= 2 and HOLD_LIMIT >= 1");
   end

   // ---------------------------------------------------------------- state
   arb_state_e              state_q, state_d;
   logic [IW-1:0]           ptr_q, ptr_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [PORTS-1:0]        grant_q, grant_d;
   logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

   // ------------------------------------------------- round-robin selection
   // Masked encoder sees only ports strictly past the pointer in search
   // order; if none request, the unmasked encoder wraps around, which leaves
   // the pointer port itself as the final candidate.
   logic [PORTS-1:0] masked_req;

   for (genvar gi = 0; gi < PORTS; gi++) begin : g_mask
      if (ARB_LSB_HIGH_PRIORITY != 0) begin : g_up
         assign masked_req[gi] = request[gi] & (IW'(gi) > ptr_q);
      end else begin : g_down
         assign masked_req[gi] = request[gi] & (IW'(gi) < ptr_q);
      end
   end

   logic          m_valid, a_valid;
   logic [IW-1:0] m_idx, a_idx;

   priority_encoder #(
      .WIDTH     (PORTS),
      .LSB_FIRST (ARB_LSB_HIGH_PRIORITY)
   ) u_pe_masked (
      .req_i   (masked_req),
      .valid_o (m_valid),
      .index_o (m_idx)
   );

   priority_encoder #(
      .WIDTH     (PORTS),
      .LSB_FIRST (ARB_LSB_HIGH_PRIORITY)
   ) u_pe_all (
      .req_i   (request),
      .valid_o (a_valid),
      .index_o (a_idx)
   );

   logic                    sel_valid;
   logic [IW-1:0]           sel_idx;
   logic [WEIGHT_WIDTH-1:0] sel_weight;
   logic [WEIGHT_WIDTH-1:0] sel_credit;

   assign sel_valid  = a_valid;
   assign sel_idx    = m_valid ? m_idx : a_idx;
   assign sel_weight = weight[int'(sel_idx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
   // A zero weight still buys one transfer so the port is never starved.
   assign sel_credit = (sel_weight == '0) ? WEIGHT_WIDTH'(1) : sel_weight;

   // ------------------------------------------------ transfer / release
   logic in_grant;
   logic transfer;
   logic revoke;
   logic release_grant;
   logic start;

   assign in_grant      = (state_q == ARB_GRANT);
   assign transfer      = in_grant & acknowledge[idx_q];
   assign release_grant = in_grant & ((transfer & (credit_q == WEIGHT_WIDTH'(1)))
                                      | ~request[idx_q]
                                      | revoke);
   // Arbitrate whenever idle or whenever the current grant ends, so a
   // release is followed directly by the next grant.
   assign start         = ~in_grant | release_grant;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      grant_d  = grant_q;
      credit_d = credit_q;
      if (start) begin
         if (sel_valid) begin
            state_d          = ARB_GRANT;
            ptr_d            = sel_idx;
            idx_d            = sel_idx;
            grant_d          = '0;
            grant_d[sel_idx] = 1'b1;
            credit_d         = sel_credit;
         end else begin
            state_d  = ARB_IDLE;
            grant_d  = '0;
            credit_d = '0;
         end
      end else if (transfer) begin
         credit_d = credit_q - WEIGHT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_IDLE;
         ptr_q    <= PTR_RST;
         idx_q    <= '0;
         grant_q  <= '0;
         credit_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         grant_q  <= grant_d;
         credit_q <= credit_d;
      end
   end

   // ------------------------------------------------------ hold timeout
`ifdef ARB_HOLD_TIMEOUT_EN
   localparam int HW = $clog2(HOLD_LIMIT + 1);

   logic [HW-1:0] hold_q, hold_d;
   logic          tmo_q;
   logic          other_req;

   assign other_req = |(request & ~grant_q);
   // Revoke only helps if someone else is waiting; a lone stalled
   // requester keeps its grant.
   assign revoke    = in_grant & (hold_q == HW'(HOLD_LIMIT)) & other_req;

   always_comb begin
      hold_d = hold_q;
      if (start | transfer) begin
         hold_d = '0;
      end else if (hold_q != HW'(HOLD_LIMIT)) begin
         hold_d = hold_q + HW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         tmo_q  <= revoke;
      end
   end

   assign timeout_event = tmo_q;
`else
   assign revoke        = 1'b0;
   assign timeout_event = 1'b0;
`endif

   // ------------------------------------------------------------ outputs
   assign grant         = grant_q;
   assign grant_valid   = in_grant;
   assign grant_encoded = idx_q;
   assign grant_credit  = credit_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
module tb_wrr_arbiter;

   localparam int PORTS = 4;
   localparam int WW    = 4;
   localparam int HL    = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [PORTS-1:0]  request;
   logic [PORTS-1:0]  acknowledge;
   logic [PORTS*WW-1:0] weight;
   logic [PORTS-1:0]  grant;
   logic              grant_valid;
   logic [1:0]        grant_encoded;
   logic [WW-1:0]     grant_credit;
   logic              timeout_event;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the current owner (-1 = none), last winner, credit.
   int m_gnt, m_ptr, m_credit, m_enc, m_hold;
   bit m_tmo;

   always #5 clk = ~clk;

   wrr_arbiter #(
      .PORTS                 (PORTS),
      .WEIGHT_WIDTH          (WW),
      .ARB_LSB_HIGH_PRIORITY (1),
      .HOLD_LIMIT            (HL)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .request       (request),
      .acknowledge   (acknowledge),
      .weight        (weight),
      .grant         (grant),
      .grant_valid   (grant_valid),
      .grant_encoded (grant_encoded),
      .grant_credit  (grant_credit),
      .timeout_event (timeout_event)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Next requester after 'after' going upward, wrapping; 'after' is last.
   function automatic int pick(input logic [PORTS-1:0] req, input int after);
      for (int k = 1; k <= PORTS; k++) begin
         int p;
         p = (after + k) % PORTS;
         if (req[p]) return p;
      end
      return -1;
   endfunction

   function automatic int load_of(input logic [PORTS*WW-1:0] w, input int p);
      int v;
      v = int'(w[p*WW +: WW]);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic model_reset();
      m_gnt = -1; m_ptr = PORTS - 1; m_credit = 0; m_enc = 0; m_hold = 0; m_tmo = 0;
   endtask

   task automatic take(input int p, input logic [PORTS*WW-1:0] w);
      m_gnt = p; m_ptr = p; m_enc = p; m_credit = load_of(w, p); m_hold = 0;
   endtask

   task automatic model_step(input logic [PORTS-1:0] req, input logic [PORTS-1:0] ack,
                             input logic [PORTS*WW-1:0] w);
      int p;
      bit xfer, rel, rev;
      logic [PORTS-1:0] own;
      m_tmo = 0;
      if (m_gnt < 0) begin
         p = pick(req, m_ptr);
         if (p >= 0) take(p, w);
      end else begin
         xfer = ack[m_gnt];
         rev  = 0;
         own  = '0;
         own[m_gnt] = 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
         rev = (m_hold == HL) && ((req & ~own) != '0);
`endif
         rel = (xfer && m_credit == 1) || !req[m_gnt] || rev;
         if (rel) begin
            m_tmo = rev;
            p = pick(req, m_gnt);
            if (p >= 0) take(p, w);
            else begin m_gnt = -1; m_credit = 0; end
         end else if (xfer) begin
            m_credit--;
            m_hold = 0;
         end else if (m_hold < HL) begin
            m_hold++;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [PORTS-1:0] eg;
      eg = '0;
      if (m_gnt >= 0) eg[m_gnt] = 1'b1;
      check_eq({tag, ".grant"},   32'(grant),         32'(eg));
      check_eq({tag, ".valid"},   32'(grant_valid),   32'(m_gnt >= 0));
      check_eq({tag, ".enc"},     32'(grant_encoded), 32'(m_enc));
      check_eq({tag, ".credit"},  32'(grant_credit),  32'(m_credit));
      check_eq({tag, ".timeout"}, 32'(timeout_event), 32'(m_tmo));
   endtask

   // Called at a falling edge: apply inputs, advance one clock, check.
   task automatic cycle(input string tag, input logic [PORTS-1:0] req,
                        input logic [PORTS-1:0] ack, input logic [PORTS*WW-1:0] w);
      request = req; acknowledge = ack; weight = w;
      model_step(req, ack, w);
      @(posedge clk);
      @(negedge clk);
      check_outputs(tag);
      $display("txn %-8s req=%b ack=%b -> grant=%b enc=%0d credit=%0d tmo=%0b",
               tag, req, ack, grant, grant_encoded, grant_credit, timeout_event);
   endtask

   // Asynchronous reset between edges; outputs must clear immediately.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_outputs("areset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_seq [8] = '{0, 0, 0, 1, 1, 2, 3, 0};
      logic [PORTS-1:0] rreq;
      logic [PORTS*WW-1:0] rw;
      int n;

      rst_n = 1'b0; request = 4'hF; acknowledge = '0; weight = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs("rst");
      rst_n = 1'b1;
      cycle("rstrel", 4'hF, 4'h0, '0);
      check_eq("rst_first", 32'(grant), 32'h1);

      // Weighted sequence: weights {3,2,1,1}, everyone requests, ack always.
      do_reset();
      cycle("wrr", 4'hF, 4'hF, 16'h1123);
      check_eq("wrr_seq0", 32'(grant_encoded), 32'(exp_seq[0]));
      for (int i = 1; i < 8; i++) begin
         cycle("wrr", 4'hF, 4'hF, 16'h1123);
         check_eq($sformatf("wrr_seq%0d", i), 32'(grant_encoded), 32'(exp_seq[i]));
         check_eq("wrr_nogap", 32'(grant_valid), 32'h1);
      end

      // Zero weight on the only requester: regranted each cycle with credit 1.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle("w0", 4'b0100, 4'hF, 16'h0000);
         check_eq("w0_enc", 32'(grant_encoded), 32'd2);
         check_eq("w0_credit", 32'(grant_credit), 32'd1);
      end

      // Withdrawal before any ack hands over on the next cycle.
      do_reset();
      cycle("drop", 4'b0010, 4'h0, 16'h0030);
      check_eq("drop_credit", 32'(grant_credit), 32'd3);
      cycle("drop", 4'b1001, 4'h0, 16'h0030);
      check_eq("drop_next", 32'(grant), 32'b1000);

      // Last ack on port 0 while 0 and 1 request: port 1 wins next.
      do_reset();
      cycle("lastack", 4'b0001, 4'h0, 16'h0001);
      cycle("lastack", 4'b0011, 4'b0001, 16'h0001);
      check_eq("lastack_next", 32'(grant), 32'b0010);

      // Stalled owner with a competitor waiting.
      do_reset();
      cycle("hold", 4'b0001, 4'h0, 16'h0001);
`ifdef ARB_HOLD_TIMEOUT_EN
      n = 0;
      while (n < 30) begin
         cycle("tmo", 4'b1001, 4'h0, 16'h0001);
         n++;
         if (timeout_event === 1'b1) break;
      end
      check_eq("tmo_cycle", 32'(n), 32'd9);
      check_eq("tmo_grant", 32'(grant), 32'b1000);
`else
      n = 0;
      repeat (100) begin
         cycle("hold", 4'b1001, 4'h0, 16'h0001);
         n++;
      end
      check_eq("hold100", 32'(grant), 32'b0001);
`endif

      // Randomized traffic against the model, with a reset mid-stream.
      do_reset();
      rreq = 4'hF;
      rw   = 16'h2131;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 49) == 0) rw = 16'($urandom_range(0, 16'hFFFF) & 16'h3333);
         if ($urandom_range(0, 3) == 0) rreq = 4'($urandom_range(0, 15));
         if (i == 300) do_reset();
         cycle("rand", rreq, 4'($urandom_range(0, 15)), rw);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
